// File: rtl/regfile_pkg.sv
// Shared widths, FSM states and the latched request record for the
// two-requester register-file arbiter.
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREGS  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] ra;
    logic [RF_ADDR_W-1:0] rb;
    logic [RF_ADDR_W-1:0] wa;
    logic [RF_DATA_W-1:0] wd;
    logic                 id;
  } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the requester that did
// not win last time goes first; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);

  always_comb begin
    gnt_o = 2'b00;
    win_o = 1'b0;
    case (valid_i)
      2'b01: begin
        gnt_o = 2'b01;
        win_o = 1'b0;
      end
      2'b10: begin
        gnt_o = 2'b10;
        win_o = 1'b1;
      end
      2'b11: begin
        win_o = ~last_grant_i;
        gnt_o = last_grant_i ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester front end to a single-port register file: one operation
// every three cycles (IDLE -> ACC -> DONE), round-robin granted.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREGS  = RF_NREGS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_ra,
  input  logic [1:0][ADDR_W-1:0] req_rb,
  input  logic [1:0][ADDR_W-1:0] req_wa,
  input  logic [1:0][DATA_W-1:0] req_wd,
  output logic [1:0]             resp_valid,
  output logic [1:0]             resp_err,
  output logic [1:0][DATA_W-1:0] resp_da,
  output logic [1:0][DATA_W-1:0] resp_db,
  output logic [ADDR_W-1:0]      rf_reg1,
  output logic [ADDR_W-1:0]      rf_reg2,
  output logic [ADDR_W-1:0]      rf_rdst,
  output logic [DATA_W-1:0]      rf_in,
  output logic                   rf_rd,
  input  logic [DATA_W-1:0]      rf_out1,
  input  logic [DATA_W-1:0]      rf_out2
);

  state_e state_q, state_d;
  logic   last_grant_q;
  req_t   op_q, win_req;
  logic   rf_rd_q;
  logic [1:0]             resp_valid_q, resp_err_q;
  logic [1:0][DATA_W-1:0] resp_da_q, resp_db_q;
  logic [1:0] gnt;
  logic       win, hs, op_err;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return int'(a) >= NREGS;
  endfunction

  rr_arbiter2 u_arb (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt),
    .win_o        (win)
  );

  assign req_ready = (state_q == IDLE) ? (gnt & req_valid) : 2'b00;
  assign hs        = |req_ready;

  always_comb begin
    win_req    = '0;
    win_req.we = req_we[win];
    win_req.ra = req_ra[win];
    win_req.rb = req_rb[win];
    win_req.wa = req_wa[win];
    win_req.wd = req_wd[win];
    win_req.id = win;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ACC;
      ACC:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign op_err = op_q.we ? addr_bad(op_q.wa)
                          : (addr_bad(op_q.ra) | addr_bad(op_q.rb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      rf_rd_q      <= 1'b1;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_da_q    <= '0;
      resp_db_q    <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= '0;
      rf_rd_q      <= 1'b1;
      if (hs) begin
        op_q         <= win_req;
        last_grant_q <= win;
        // Write strobe is launched from the flop so it is low for all of ACC
        if (win_req.we && !addr_bad(win_req.wa)) rf_rd_q <= 1'b0;
      end
      if (state_q == ACC) begin
        resp_valid_q[op_q.id] <= 1'b1;
        resp_err_q[op_q.id]   <= op_err;
        resp_da_q[op_q.id]    <= (op_q.we || op_err) ? '0 : rf_out1;
        resp_db_q[op_q.id]    <= (op_q.we || op_err) ? '0 : rf_out2;
      end
    end
  end

  // Register-file address/data come straight from the latched op and hold between ops
  assign rf_reg1    = op_q.ra;
  assign rf_reg2    = op_q.rb;
  assign rf_rdst    = op_q.wa;
  assign rf_in      = op_q.wd;
  assign rf_rd      = rf_rd_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_da    = resp_da_q;
  assign resp_db    = resp_db_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: register-file model, transaction-level reference
// with per-cycle compare, directed scenarios, then randomized traffic.
module tb_regfile_arbiter;
  import regfile_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]         req_valid = '0, req_we = '0;
  logic [1:0][AW-1:0] req_ra = '0, req_rb = '0, req_wa = '0;
  logic [1:0][DW-1:0] req_wd = '0;
  logic [1:0]         req_ready, resp_valid, resp_err;
  logic [1:0][DW-1:0] resp_da, resp_db;
  logic [AW-1:0]      rf_reg1, rf_reg2, rf_rdst;
  logic [DW-1:0]      rf_in, rf_out1, rf_out2;
  logic               rf_rd;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ra(req_ra), .req_rb(req_rb), .req_wa(req_wa), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_da(resp_da), .resp_db(resp_db),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_rdst(rf_rdst), .rf_in(rf_in),
    .rf_rd(rf_rd), .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  always #5 clk = ~clk;

  // Register file the DUT drives: combinational read, write while rf_rd is low
  logic [DW-1:0] mem [32] = '{default: '0};
  assign rf_out1 = mem[rf_reg1];
  assign rf_out2 = mem[rf_reg2];
  always @(posedge clk) if (rst_n && !rf_rd) mem[rf_rdst] <= rf_in;

  function automatic void chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: one op in flight, ACC one cycle after the grant, DONE two after
  logic [DW-1:0] mmem [NR] = '{default: '0};
  int   next_ok = 0;
  logic m_lg = 1'b1;
  logic p_vld = 1'b0, p_id, p_we, p_err;
  int   p_cyc = 0;
  logic [AW-1:0] p_ra, p_rb, p_wa;
  logic [DW-1:0] p_wd, p_da, p_db;
  logic [1:0]         last_err = '0;
  logic [1:0][DW-1:0] last_da = '0, last_db = '0;

  always @(negedge clk) begin : cmp
    logic [1:0] er, erv;
    logic exp_rd, w;
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rf_rd", rf_rd, 1);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_da", resp_da, 0);
      chk("rst_resp_db", resp_db, 0);
      chk("rst_rf_addr", {rf_reg1, rf_reg2, rf_rdst}, 0);
      chk("rst_rf_in", rf_in, 0);
      p_vld = 1'b0; m_lg = 1'b1; next_ok = cyc + 1;
      last_err = '0; last_da = '0; last_db = '0;
    end else begin
      exp_rd = 1'b1;
      if (p_vld && cyc == p_cyc + 1) begin
        if (p_we && p_wa < NR) begin
          exp_rd = 1'b0;
          chk("acc_rf_rdst", rf_rdst, p_wa);
          chk("acc_rf_in", rf_in, p_wd);
          mmem[p_wa] = p_wd;
        end else if (!p_we) begin
          chk("acc_rf_reg1", rf_reg1, p_ra);
          chk("acc_rf_reg2", rf_reg2, p_rb);
        end
      end
      chk("rf_rd", rf_rd, exp_rd);
      erv = 2'b00;
      if (p_vld && cyc == p_cyc + 2) begin
        erv[p_id] = 1'b1;
        last_err[p_id] = p_err; last_da[p_id] = p_da; last_db[p_id] = p_db;
        p_vld = 1'b0;
      end
      chk("resp_valid", resp_valid, erv);
      chk("resp_err", resp_err, last_err);
      chk("resp_da", resp_da, last_da);
      chk("resp_db", resp_db, last_db);
      er = 2'b00;
      if (cyc >= next_ok)
        er = (req_valid == 2'b11) ? (m_lg ? 2'b01 : 2'b10) : req_valid;
      chk("req_ready", req_ready, er);
      if (er != 2'b00) begin
        w = er[1];
        p_vld = 1'b1; p_cyc = cyc; p_id = w; p_we = req_we[w];
        p_ra = req_ra[w]; p_rb = req_rb[w]; p_wa = req_wa[w]; p_wd = req_wd[w];
        p_err = p_we ? (p_wa >= NR) : (p_ra >= NR || p_rb >= NR);
        p_da = '0; p_db = '0;
        if (!p_we && !p_err) begin p_da = mmem[p_ra]; p_db = mmem[p_rb]; end
        next_ok = cyc + 3; m_lg = w;
      end
    end
    cyc++;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue one request, wait for its grant, return what DONE showed
  task automatic op(input int id, input bit we, input int ra, input int rb, input int wa,
                    input logic [DW-1:0] wd, output logic rd_acc, output logic err,
                    output logic [DW-1:0] da, output logic [DW-1:0] db);
    bit got;
    got = 0; rd_acc = 1'b1; err = 1'b0; da = '0; db = '0;
    @(posedge clk); #1;
    req_valid[id] = 1'b1; req_we[id] = we;
    req_ra[id] = AW'(ra); req_rb[id] = AW'(rb); req_wa[id] = AW'(wa); req_wd[id] = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    @(posedge clk); #1 req_valid[id] = 1'b0;
    if (!got) begin
      chk("handshake_timeout", 0, 1);
    end else begin
      @(negedge clk); rd_acc = rf_rd;
      @(negedge clk);
      chk("done_pulse_latency2", resp_valid[id], 1);
      err = resp_err[id]; da = resp_da[id]; db = resp_db[id];
    end
  endtask

  initial begin
    logic rd, e;
    logic [DW-1:0] a, b;
    int gid [6];
    int gcy [3];
    int n, t;
    bit ok;

    do_reset();

    // Read after populating reg[2]=3, reg[5]=6
    op(0, 1, 0, 0, 2, 16'd3, rd, e, a, b);
    op(0, 1, 0, 0, 5, 16'd6, rd, e, a, b);
    op(0, 0, 2, 5, 0, 16'd0, rd, e, a, b);
    chk("s1_da", a, 16'd3); chk("s1_db", b, 16'd6); chk("s1_err", e, 0);

    // Write then read same address from requester 1
    op(1, 1, 0, 0, 7, 16'hABCD, rd, e, a, b);
    chk("s2_wr_rd_low", rd, 0); chk("s2_wr_err", e, 0);
    op(1, 0, 7, 7, 0, 16'd0, rd, e, a, b);
    chk("s2_da", a, 16'hABCD); chk("s2_db", b, 16'hABCD); chk("s2_rd_high", rd, 1);

    // Out-of-range addresses
    op(0, 1, 0, 0, 20, 16'h1111, rd, e, a, b);
    chk("s4_wr_err", e, 1); chk("s4_wr_rd_high", rd, 1);
    op(0, 0, 16, 2, 0, 16'd0, rd, e, a, b);
    chk("s4_rd_err", e, 1); chk("s4_rd_da", a, 0); chk("s4_rd_db", b, 0);

    // Reset during ACC of a write abandons it
    op(0, 1, 0, 0, 3, 16'h5A5A, rd, e, a, b);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wa[0] = AW'(3); req_wd[0] = 16'hDEAD;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1;
    end
    chk("s5_grant", ok, 1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    chk("s5_acc_rd_low", rf_rd, 0);
    #1 rst_n = 1'b0;
    #1 chk("s5_async_rd_high", rf_rd, 1);
    @(negedge clk); chk("s5_no_resp", resp_valid, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    chk("s5_mem_unchanged", mem[3], 16'h5A5A);
    op(0, 0, 3, 3, 0, 16'd0, rd, e, a, b);
    chk("s5_readback", a, 16'h5A5A);

    // Contention from reset
    do_reset();
    @(posedge clk); #1;
    req_we = 2'b00; req_ra = '0; req_rb = '0; req_valid = 2'b11;
    n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin gid[n] = req_ready[1] ? 1 : 0; n++; end
    end
    @(posedge clk); #1 req_valid = 2'b00;
    chk("s3_grants", n, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("s3_order%0d", k), gid[k], k % 2);

    // Lone requester 1, even though it won last
    @(posedge clk); #1;
    req_we[1] = 1'b0; req_ra[1] = AW'(7); req_rb[1] = AW'(2); req_valid[1] = 1'b1;
    n = 0; t = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin gcy[n] = t; n++; end
      t++;
    end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    chk("s6_grants", n, 3);
    if (n == 3) begin
      chk("s6_gap1", gcy[1] - gcy[0], 3);
      chk("s6_gap2", gcy[2] - gcy[1], 3);
    end

    // Random traffic, checked by the reference every cycle
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      req_we    = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        req_ra[r] = AW'($urandom_range(0, 19));
        req_rb[r] = AW'($urandom_range(0, 19));
        req_wa[r] = AW'($urandom_range(0, 19));
        req_wd[r] = DW'($urandom);
      end
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
